// File: rtl/led_serializer.sv
// rtl/led_serializer.sv - serializes 16-bit grayscale words onto DAI/DEN with a fixed inter-word gap
// Optional build macro LEDSER_MSB_FIRST_EN: shift MSB first instead of LSB first.
module led_serializer #(
  parameter int WORDS_PER_FRAME = 512,
  parameter int GAP_CYCLES      = 2
) (
  input  logic        DCK,
  input  logic        rst_n,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        abort,
  output logic        DAI,
  output logic        DEN,
  output logic        frame_done,
  output logic [8:0]  word_idx
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [8:0] LAST_IDX = 9'(WORDS_PER_FRAME - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [15:0] sr_q;
  logic [15:0] sr_d;
  logic [15:0] sr_src;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic [8:0]  idx_q;
  logic        ready_q;
  logic        dai_q;
  logic        den_q;
  logic        done_q;
  logic        dai_d;
  logic        handshake;

  // abort masks ready in the same cycle so it always wins over a handshake
  assign word_ready = ready_q & ~abort;
  assign handshake  = word_valid & word_ready;

  assign DAI        = dai_q;
  assign DEN        = den_q;
  assign frame_done = done_q;
  assign word_idx   = idx_q;

  always_comb begin
    sr_src = (state_q == IDLE) ? word_in : sr_q;
`ifdef LEDSER_MSB_FIRST_EN
    dai_d  = sr_src[15];
    sr_d   = {sr_src[14:0], 1'b0};
`else
    dai_d  = sr_src[0];
    sr_d   = {1'b0, sr_src[15:1]};
`endif
  end

  always_ff @(posedge DCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= 16'h0000;
      bit_cnt_q <= 4'd0;
      gap_cnt_q <= 4'd0;
      idx_q     <= 9'd0;
      ready_q   <= 1'b0;
      dai_q     <= 1'b0;
      den_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort) begin
      state_q   <= IDLE;
      sr_q      <= 16'h0000;
      bit_cnt_q <= 4'd0;
      gap_cnt_q <= 4'd0;
      idx_q     <= 9'd0;
      ready_q   <= 1'b1;
      dai_q     <= 1'b0;
      den_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (handshake) begin
            state_q   <= SHIFT;
            ready_q   <= 1'b0;
            den_q     <= 1'b1;
            dai_q     <= dai_d;
            sr_q      <= sr_d;
            bit_cnt_q <= 4'd0;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == 4'd15) begin
            state_q   <= GAP;
            den_q     <= 1'b0;
            dai_q     <= 1'b0;
            gap_cnt_q <= 4'd0;
          end else begin
            dai_q     <= dai_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_q  <= 9'd0;
              done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 9'd1;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_serializer.sv
// tb/tb_led_serializer.sv - scoreboard bench for led_serializer
module tb_led_serializer;

  localparam int WPF = 512;
  localparam int GAP = 2;

  logic        DCK = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] word_in = 16'h0000;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        abort = 1'b0;
  logic        DAI;
  logic        DEN;
  logic        frame_done;
  logic [8:0]  word_idx;

  always #5 DCK = ~DCK;

  led_serializer #(.WORDS_PER_FRAME(WPF), .GAP_CYCLES(GAP)) dut (
    .DCK        (DCK),
    .rst_n      (rst_n),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .abort      (abort),
    .DAI        (DAI),
    .DEN        (DEN),
    .frame_done (frame_done),
    .word_idx   (word_idx)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  int          bursts = 0;
  int          fd_count = 0;
  int          since = 1000;
  bit          drop_next = 0;
  int          drop_len = 0;
  logic [15:0] col = 16'h0000;
  int          col_n = 0;
  logic        den_prev = 1'b0;
  logic [15:0] e_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [15:0] w, input int i);
`ifdef LEDSER_MSB_FIRST_EN
    return w[15-i];
`else
    return w[i];
`endif
  endfunction

  // Monitor: rebuild each DEN burst into a word and compare against the scoreboard
  always @(negedge DCK) begin
    if (!rst_n) begin
      col_n    = 0;
      col      = 16'h0000;
      den_prev = 1'b0;
      since    = 1000;
    end else begin
      since++;
      if (DEN) begin
        if (col_n < 16) begin
`ifdef LEDSER_MSB_FIRST_EN
          col[15-col_n] = DAI;
`else
          col[col_n] = DAI;
`endif
        end
        col_n++;
      end else if (den_prev) begin
        since = 0;
        if (drop_next) begin
          drop_next = 0;
          chk("abort_len", col_n, drop_len);
        end else begin
          chk("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e_w = exp_q.pop_front();
            chk("sb_word", col, e_w);
            chk("sb_len", col_n, 16);
          end
          bursts++;
        end
        col_n = 0;
        col   = 16'h0000;
      end
      if (frame_done) begin
        fd_count++;
        chk("fd_gap", since, GAP);
      end
      den_prev = DEN;
    end
  end

  task automatic send_word(input logic [15:0] w, input bit expect_it);
    int t = 0;
    word_in    = w;
    word_valid = 1'b1;
    while (!word_ready && t < 60) begin
      @(negedge DCK);
      t++;
    end
    chk("hs_timeout", t < 60, 1);
    if (expect_it && t < 60) exp_q.push_back(w);
    @(posedge DCK);
    #1;
    word_valid = 1'b0;
    word_in    = 16'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!word_ready && t < 60) begin
      @(negedge DCK);
      t++;
    end
    chk("idle_timeout", t < 60, 1);
  endtask

  initial begin
    logic [15:0] dw;
    int b0;
    #12;
    chk("rst_ready", word_ready, 0);
    chk("rst_den", DEN, 0);
    chk("rst_dai", DAI, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_idx", word_idx, 0);
    @(negedge DCK);
    rst_n = 1'b1;
    @(posedge DCK);
    #1;
    chk("ready_after_reset", word_ready, 1);

    // Directed single word with exact per-cycle timing
`ifdef LEDSER_MSB_FIRST_EN
    dw = 16'h8001;
`else
    dw = 16'hA5C3;
`endif
    word_in    = dw;
    word_valid = 1'b1;
    exp_q.push_back(dw);
    @(posedge DCK);
    for (int i = 0; i < 16; i++) begin
      @(negedge DCK);
      chk("dir_den", DEN, 1);
      chk("dir_dai", DAI, exp_bit(dw, i));
      chk("dir_ready", word_ready, 0);
    end
    for (int i = 0; i < GAP; i++) begin
      @(negedge DCK);
      chk("gap_den", DEN, 0);
      chk("gap_dai", DAI, 0);
      chk("gap_ready", word_ready, 0);
    end
    @(negedge DCK);
    chk("ready_back", word_ready, 1);
    chk("idx_after_one", word_idx, 1);
    word_valid = 1'b0;

    // Abort in IDLE together with a valid word: no handshake, index cleared
    @(negedge DCK);
    abort      = 1'b1;
    word_valid = 1'b1;
    word_in    = 16'h1234;
    #1;
    chk("ready_during_abort", word_ready, 0);
    @(posedge DCK);
    #1;
    abort      = 1'b0;
    word_valid = 1'b0;
    chk("idle_abort_idx", word_idx, 0);
    chk("idle_abort_den", DEN, 0);
    chk("idle_abort_fd", frame_done, 0);
    @(negedge DCK);
    chk("idle_abort_no_hs", DEN, 0);
    chk("ready_after_abort", word_ready, 1);

    // Full frame of back-to-back words
    b0 = bursts;
    for (int w = 0; w < WPF; w++) begin
      if (w == WPF - 1) chk("no_fd_early", fd_count, 0);
      send_word(16'(w), 1'b1);
      if (w == 256) chk("idx_mid", word_idx, 256);
    end
    wait_idle();
    @(negedge DCK);
    @(negedge DCK);
    chk("fd_count", fd_count, 1);
    chk("fd_low_after", frame_done, 0);
    chk("idx_wrap", word_idx, 0);
    chk("frame_bursts", bursts - b0, WPF);

    // Abort at bit 7 of word 5
    for (int w = 0; w < 5; w++) send_word(16'h0F00 + 16'(w), 1'b1);
    send_word(16'h5A5A, 1'b0);
    repeat (7) @(posedge DCK);
    #1;
    chk("idx_before_abort", word_idx, 5);
    drop_len  = 8;
    drop_next = 1;
    abort     = 1'b1;
    @(posedge DCK);
    #1;
    abort = 1'b0;
    chk("abort_den", DEN, 0);
    chk("abort_dai", DAI, 0);
    chk("abort_idx", word_idx, 0);
    chk("abort_fd", frame_done, 0);
    send_word(16'hFFFF, 1'b1);
    wait_idle();

    // Reset at bit 3 of 16'hFFFF
    send_word(16'hFFFF, 1'b0);
    repeat (3) @(posedge DCK);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_den", DEN, 0);
    chk("arst_dai", DAI, 0);
    chk("arst_ready", word_ready, 0);
    chk("arst_idx", word_idx, 0);
    @(negedge DCK);
    @(negedge DCK);
    rst_n = 1'b1;
    @(posedge DCK);
    #1;
    chk("arst_ready_back", word_ready, 1);
    send_word(16'h3C96, 1'b1);
    wait_idle();

    // word_valid toggling during SHIFT/GAP must not cause extra handshakes
    b0 = bursts;
    send_word(16'hC0DE, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      word_valid = ~word_valid;
      word_in    = 16'($urandom);
      if (i == 9) chk("toggle_ready", word_ready, 0);
      @(posedge DCK);
      #1;
    end
    word_valid = 1'b0;
    wait_idle();
    @(negedge DCK);
    @(negedge DCK);
    chk("toggle_bursts", bursts - b0, 1);

    repeat (5) @(negedge DCK);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/led_serializer.md
LED_SERIALIZER -- requirements
Module: led_serializer

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 512, meaning words per frame (32 scanlines x 16 channels).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, range 1..15, meaning DEN-low cycles after each word.
REQ-003 SHALL have port DCK, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port word_in, input, 16 bits: grayscale word to send.
REQ-006 SHALL have port word_valid, input, 1 bit: word_in holds a valid word.
REQ-007 SHALL have port word_ready, output, 1 bit: the block accepts word_in on this edge.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the current frame.
REQ-009 SHALL have port DAI, output, 1 bit: serial data into the LED driver.
REQ-010 SHALL have port DEN, output, 1 bit: serial data enable into the LED driver.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last word of a frame.
REQ-012 SHALL have port word_idx, output, 9 bits: index of the word currently or next being sent.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and GAP; DAI, DEN and word_ready SHALL be registered outputs.
REQ-014 In IDLE, word_ready SHALL be 1, DEN 0 and DAI 0.
REQ-015 In SHIFT and GAP, word_ready SHALL be 0.
REQ-016 A handshake SHALL occur on any edge with word_valid=1 and word_ready=1; word_in is captured into a 16-bit shift register.
REQ-017 On the handshake edge, DEN SHALL go to 1 and DAI SHALL take bit 0, with state changing to SHIFT and bit_cnt cleared to 0.
REQ-018 In SHIFT, each edge SHALL advance one bit; DAI carries bits 0..15 on 16 consecutive cycles, LSB first.
REQ-019 DEN SHALL stay 1 for exactly those 16 cycles.
REQ-020 On the edge after bit 15, DEN SHALL go to 0 and DAI to 0, and state SHALL change to GAP.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, then state SHALL change to IDLE.
REQ-022 Minimum word period SHALL be 16+GAP_CYCLES+1 cycles (19 at the default).
REQ-023 word_idx SHALL increment on leaving GAP.
REQ-024 When the word leaving GAP has word_idx=WORDS_PER_FRAME-1, word_idx SHALL wrap to 0 and frame_done SHALL pulse high for that one cycle (the IDLE entry cycle).
REQ-025 word_valid without word_ready SHALL be ignored; word_in changes outside the handshake edge SHALL have no effect.
REQ-026 abort=1 in any state SHALL, on the next edge, force IDLE with DEN=0, DAI=0, word_idx=0 and frame_done=0.
REQ-027 A word whose DEN was interrupted by abort SHALL be discarded, not resent.
REQ-028 abort SHALL take priority over a simultaneous handshake; word_ready SHALL be 0 while abort=1.
REQ-029 abort asserted in IDLE with no frame active SHALL still clear word_idx to 0.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force IDLE, DAI=0, DEN=0, word_ready=0, frame_done=0, word_idx=0, bit_cnt=0 and the shift register to 0.
REQ-031 On the first edge after rst_n rises, word_ready SHALL go to 1.
REQ-032 Reset asserted mid-word SHALL drop DEN at once and SHALL lose the partial word.

Configuration
REQ-033 Macro LEDSER_MSB_FIRST_EN SHALL select bit order: defined gives MSB first (bit 15 on the handshake edge, bit 0 last); undefined gives LSB first (REQ-018); all timing SHALL be identical in both builds.

Verification
REQ-034 Reset, then word_in=16'hA5C3 with word_valid held: DEN high 16 cycles; DAI=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; then DEN low 2 cycles; word_ready back at cycle 19.
REQ-035 512 back-to-back words 0x0000..0x01FF: frame_done pulses once, one cycle after the gap of word 511; word_idx reads 0 afterwards; 512 DEN bursts observed.
REQ-036 abort at bit 7 of word 5: next edge DEN=0, word_idx=0; following word 0xFFFF is sent in full; no remainder of word 5 appears.
REQ-037 rst_n low at bit 3 of 16'hFFFF: DEN and DAI drop to 0 asynchronously; after release, word_ready=1 on the first edge and the next word is sent intact.
REQ-038 word_valid toggling 0/1 every cycle during SHIFT: no extra handshake, DAI is unaffected, exactly one word is accepted per IDLE visit.
REQ-039 LEDSER_MSB_FIRST_EN defined, word 16'h8001: DAI=1, fourteen 0s, then 1; DEN timing identical to REQ-034.
